// File: rtl/fir_pe_array.sv
// Transposed-form FIR engine with N_TAPS MAC stages and serially loadable coefficients.
// Define FIR_PE_ARRAY_SAT_EN to saturate Yout instead of wrapping it to Y_WIDTH bits.
module fir_pe_array #(
    parameter int unsigned N_TAPS  = 8,
    parameter int unsigned X_WIDTH = 4,
    parameter int unsigned C_WIDTH = 6,
    parameter int unsigned Y_WIDTH = 16,
    parameter int unsigned SHIFT   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Rdy,
    input  logic [X_WIDTH-1:0] Xin,
    input  logic               Clr,
    input  logic               Cload,
    input  logic [C_WIDTH-1:0] Cin,
    output logic               Vld,
    output logic [Y_WIDTH-1:0] Yout,
    output logic               Busy
);

    localparam int unsigned ACC_W = X_WIDTH + C_WIDTH + $clog2(N_TAPS);
    localparam int unsigned P_W   = X_WIDTH + C_WIDTH;
    localparam int unsigned CNT_W = $clog2(N_TAPS);
    localparam int unsigned EXT_W = (ACC_W > Y_WIDTH) ? ACC_W : Y_WIDTH;

    generate
        if (N_TAPS < 2) begin : g_taps_check
            $error("fir_pe_array: N_TAPS must be at least 2");
        end
    endgenerate

    typedef enum logic [0:0] {StRun, StLoad} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_WIDTH-1:0] coef_q [N_TAPS];
    logic [C_WIDTH-1:0] coef_d [N_TAPS];
    // Stage 0's partial sum is the filter output itself, so only stages 1..N-1 are stored.
    logic [ACC_W-1:0]   psum_q [1:N_TAPS-1];
    logic [ACC_W-1:0]   psum_d [1:N_TAPS-1];
    logic [P_W-1:0]     prod   [N_TAPS];
    logic [ACC_W-1:0]   tap_sum[N_TAPS];
    logic               accept;
    logic               load_done;
    logic [EXT_W-1:0]   shifted;
    logic [Y_WIDTH-1:0] y_red;
    logic               vld_q;
    logic [Y_WIDTH-1:0] yout_q;

    // Multipliers and the transposed adder chain
    generate
        for (genvar k = 0; k < N_TAPS; k++) begin : g_mul
            assign prod[k] = {{X_WIDTH{1'b0}}, coef_q[k]} * {{C_WIDTH{1'b0}}, Xin};
        end
        for (genvar k = 0; k < N_TAPS - 1; k++) begin : g_add
            assign tap_sum[k] = psum_q[k+1] + {{(ACC_W-P_W){1'b0}}, prod[k]};
        end
    endgenerate
    assign tap_sum[N_TAPS-1] = {{(ACC_W-P_W){1'b0}}, prod[N_TAPS-1]};

    assign accept    = (state_q == StRun) && Rdy && !Cload && !Clr;
    assign load_done = (state_q == StLoad) && Cload && (cnt_q == CNT_W'(N_TAPS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (Cload) state_d = StLoad;
            StLoad:  if (load_done) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM outputs
    always_comb begin
        Busy = (state_q == StLoad);
    end

    // Coefficient shift register, load counter and partial-sum next state
    always_comb begin
        coef_d = coef_q;
        psum_d = psum_q;
        cnt_d  = cnt_q;
        if (Cload) begin
            for (int k = 0; k < int'(N_TAPS) - 1; k++) begin
                coef_d[k] = coef_q[k+1];
            end
            coef_d[N_TAPS-1] = Cin;
            if (state_q == StRun) begin
                cnt_d = CNT_W'(1);
            end else if (load_done) begin
                cnt_d = '0;
                for (int k = 1; k < int'(N_TAPS); k++) begin
                    psum_d[k] = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if ((state_q == StRun) && Clr) begin
            for (int k = 1; k < int'(N_TAPS); k++) begin
                psum_d[k] = '0;
            end
        end else if (accept) begin
            for (int k = 1; k < int'(N_TAPS); k++) begin
                psum_d[k] = tap_sum[k];
            end
        end
    end

    // Output width reduction
    always_comb begin
        shifted = EXT_W'(tap_sum[0] >> SHIFT);
`ifdef FIR_PE_ARRAY_SAT_EN
        if (shifted > EXT_W'({Y_WIDTH{1'b1}})) begin
            y_red = '1;
        end else begin
            y_red = shifted[Y_WIDTH-1:0];
        end
`else
        y_red = Y_WIDTH'(shifted);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            yout_q <= '0;
            for (int k = 0; k < int'(N_TAPS); k++) begin
                coef_q[k] <= '0;
            end
            for (int k = 1; k < int'(N_TAPS); k++) begin
                psum_q[k] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            vld_q  <= accept;
            coef_q <= coef_d;
            psum_q <= psum_d;
            if (accept) begin
                yout_q <= y_red;
            end
        end
    end

    assign Vld  = vld_q;
    assign Yout = yout_q;

endmodule
